multi_digit_counter: RTL and testbench

Parametrised up/down counter with NUM_DIGITS hex digits and registered 7-segment drive for each digit. It is the successor to the fixed 8-bit, button-clocked counter. It runs on the system clock and advances on a synchronised, edge-detected step input. It adds load, direction, programmable rollover, a rollover pulse, and optional BCD counting. It sits between board push-buttons and the HEXn displays in lab top levels.

---
 rtl/multi_digit_counter.sv | 178 +++++++++++++++++
 tb/tb_multi_digit_counter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_digit_counter.sv
// NUM_DIGITS-digit up/down counter stepped by a synchronised, edge-detected push-button,
// with load, clear, programmable rollover and registered 7-segment drive. Define BCD_MODE_EN for decimal digits.
module multi_digit_counter #(
  parameter int NUM_DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    step_in,
  input  logic                    count_enable,
  input  logic                    up_down,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  input  logic [4*NUM_DIGITS-1:0] rollover_val,
  output logic [4*NUM_DIGITS-1:0] count_out,
  output logic                    rollover_flag,
  output logic [7*NUM_DIGITS-1:0] hex_out
);

  localparam int W = 4 * NUM_DIGITS;
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic                  r_sync1;
  logic                  r_sync2;
  logic                  r_sync2_d;
  logic [W-1:0]          r_count;
  logic                  r_flag;
  logic [7*NUM_DIGITS-1:0] r_hex;

  logic                  w_step_pulse;
  logic [W-1:0]          w_next_count;
  logic                  w_next_flag;
  logic [7*NUM_DIGITS-1:0] w_hex;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

`ifdef BCD_MODE_EN
  // Decimal ripple: digits at 9 or above (illegal A-F included) wrap to 0 and carry.
  function automatic logic [W-1:0] cnt_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] cnt_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction
`else
  function automatic logic [W-1:0] cnt_inc(input logic [W-1:0] v);
    return v + ONE;
  endfunction

  function automatic logic [W-1:0] cnt_dec(input logic [W-1:0] v);
    return v - ONE;
  endfunction
`endif

  // Step synchroniser and edge detector; resetting high swallows a button held through reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_sync2_d <= 1'b1;
    end else begin
      r_sync1   <= step_in;
      r_sync2   <= r_sync1;
      r_sync2_d <= r_sync2;
    end
  end

  assign w_step_pulse = r_sync2 & ~r_sync2_d;

  // Next count: clear > load > enabled step; a pulse colliding with clear/load is dropped
  always_comb begin
    w_next_count = r_count;
    w_next_flag  = 1'b0;
    if (clear) begin
      w_next_count = '0;
    end else if (load) begin
      w_next_count = load_val;
    end else if (w_step_pulse && count_enable) begin
      if (up_down) begin
        if (r_count >= rollover_val) begin
          w_next_count = '0;
          w_next_flag  = 1'b1;
        end else begin
          w_next_count = cnt_inc(r_count);
        end
      end else begin
        if (r_count == '0) begin
          w_next_count = rollover_val;
          w_next_flag  = 1'b1;
        end else begin
          w_next_count = cnt_dec(r_count);
        end
      end
    end else begin
      w_next_count = r_count;
    end
  end

  // Segment decode of the registered count
  always_comb begin
    w_hex = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_hex[7*i +: 7] = seg7(r_count[4*i +: 4]);
    end
  end

  // Count, rollover pulse and display registers; hex trails the count by one edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_flag  <= 1'b0;
      r_hex   <= {NUM_DIGITS{7'h40}};
    end else begin
      r_count <= w_next_count;
      r_flag  <= w_next_flag;
      r_hex   <= w_hex;
    end
  end

  assign count_out     = r_count;
  assign rollover_flag = r_flag;
  assign hex_out       = r_hex;

endmodule

// File: tb/tb_multi_digit_counter.sv
// Randomised bench for multi_digit_counter against an arithmetic reference model,
// with directed literal checks for latency, wrap, priority and rollover corner cases.
module tb_multi_digit_counter;
  localparam int ND = 2;
  localparam int W  = 4 * ND;

  logic            clk = 1'b0;
  logic            rst, step_in, count_enable, up_down, clear, load;
  logic [W-1:0]    load_val, rollover_val, count_out;
  logic            rollover_flag;
  logic [7*ND-1:0] hex_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  multi_digit_counter #(.NUM_DIGITS(ND)) dut (
    .clk(clk), .rst(rst), .step_in(step_in), .count_enable(count_enable),
    .up_down(up_down), .clear(clear), .load(load), .load_val(load_val),
    .rollover_val(rollover_val), .count_out(count_out),
    .rollover_flag(rollover_flag), .hex_out(hex_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = ND - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int x);
    logic [W-1:0] r = '0;
    int y = x;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(y % 10);
      y = y / 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bump(input logic [W-1:0] v, input int d);
`ifdef BCD_MODE_EN
    return int2bcd(bcd2int(v) + d);
`else
    return v + W'(d);
`endif
  endfunction

  function automatic logic [7*ND-1:0] hex_of(input logic [W-1:0] v);
    logic [7*ND-1:0] h;
    for (int i = 0; i < ND; i++) h[7*i +: 7] = SEG[v[4*i +: 4]];
    return h;
  endfunction

  function automatic logic [W-1:0] rand_val();
`ifdef BCD_MODE_EN
    return int2bcd(int'($urandom_range(0, 99)));
`else
    return W'($urandom);
`endif
  endfunction

  // Reference model: step_in as sampled at each edge; anything up to the last reset reads as high.
  logic            samp [64];
  int              cyc = 0;
  int              last_rst = 0;
  bit              started = 1'b0;
  logic [W-1:0]    m_cnt;
  logic            m_flag;
  logic [7*ND-1:0] m_hex;

  function automatic logic eff(input int k);
    return (k <= last_rst) ? 1'b1 : samp[k & 63];
  endfunction

  always @(posedge clk) begin : model
    logic         pulse;
    logic [W-1:0] c;
    logic         f;
    pulse = eff(cyc - 2) & ~eff(cyc - 3);
    c = m_cnt;
    f = 1'b0;
    if (clear) c = '0;
    else if (load) c = load_val;
    else if (pulse && count_enable) begin
      if (up_down) begin
        if (m_cnt >= rollover_val) begin c = '0; f = 1'b1; end
        else c = bump(m_cnt, 1);
      end else begin
        if (m_cnt == '0) begin c = rollover_val; f = 1'b1; end
        else c = bump(m_cnt, -1);
      end
    end
    samp[cyc & 63] <= step_in;
    cyc <= cyc + 1;
    if (rst) begin
      m_cnt    <= '0;
      m_flag   <= 1'b0;
      m_hex    <= {ND{7'h40}};
      last_rst <= cyc;
      started  <= 1'b1;
    end else begin
      m_cnt  <= c;
      m_flag <= f;
      m_hex  <= hex_of(m_cnt);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_count", 64'(count_out), 64'(m_cnt));
      chk("model_flag", 64'(rollover_flag), 64'(m_flag));
      chk("model_hex", 64'(hex_out), 64'(m_hex));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle step_in pulse; returns just after the edge that applies it.
  task automatic do_step();
    step_in = 1'b1;
    tick(1);
    step_in = 1'b0;
    tick(2);
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load_val = v;
    load = 1'b1;
    tick(1);
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; step_in = 1'b1; count_enable = 1'b1; up_down = 1'b1;
    clear = 1'b0; load = 1'b0; load_val = '0; rollover_val = {W{1'b1}};
    tick(2);
    chk("reset_count", 64'(count_out), 64'h00);
    chk("reset_flag", 64'(rollover_flag), 64'h0);
    chk("reset_hex", 64'(hex_out), 64'h2040);
    rst = 1'b0;
    tick(10);
    chk("held_step_no_count", 64'(count_out), 64'h00);

    // Latency: count on the 3rd edge, display on the 4th; a wide pulse counts once
    step_in = 1'b0;
    tick(4);
    step_in = 1'b1;
    tick(2);
    chk("lat_edge2", 64'(count_out), 64'h00);
    tick(1);
    chk("lat_edge3", 64'(count_out), 64'h01);
    chk("lat_hex_edge3", 64'(hex_out), 64'h2040);
    tick(1);
    chk("lat_hex_edge4", 64'(hex_out), 64'h2079);
    tick(16);
    step_in = 1'b0;
    tick(4);
    chk("wide_pulse_once", 64'(count_out), 64'h01);

`ifndef BCD_MODE_EN
    rollover_val = 8'h0F;
    do_load(8'h0E);
    do_step();
    chk("wrap_0F", 64'(count_out), 64'h0F);
    chk("wrap_0F_flag", 64'(rollover_flag), 64'h0);
    do_step();
    chk("wrap_00", 64'(count_out), 64'h00);
    chk("wrap_00_flag", 64'(rollover_flag), 64'h1);
    tick(1);
    chk("wrap_flag_one_cycle", 64'(rollover_flag), 64'h0);
    up_down = 1'b0;
    do_step();
    chk("under_0F", 64'(count_out), 64'h0F);
    chk("under_flag", 64'(rollover_flag), 64'h1);
    up_down = 1'b1;
`endif

    // Priority: clear+load on the step's edge discards the step
    rollover_val = 8'hFF;
    step_in = 1'b1;
    tick(1);
    step_in = 1'b0;
    tick(1);
    clear = 1'b1; load = 1'b1; load_val = 8'h55;
    tick(1);
    chk("prio_clear", 64'(count_out), 64'h00);
    chk("prio_no_flag", 64'(rollover_flag), 64'h0);
    clear = 1'b0; load = 1'b0;
    count_enable = 1'b0;
    do_load(8'h55);
    chk("load_disabled", 64'(count_out), 64'h55);
    do_step();
    chk("step_disabled", 64'(count_out), 64'h55);
    count_enable = 1'b1;

    rollover_val = 8'h00;
    do_step();
    chk("rv0_up", 64'(count_out), 64'h00);
    chk("rv0_up_flag", 64'(rollover_flag), 64'h1);
    do_step();
    chk("rv0_up2_flag", 64'(rollover_flag), 64'h1);
    up_down = 1'b0;
    do_step();
    chk("rv0_down", 64'(count_out), 64'h00);
    chk("rv0_down_flag", 64'(rollover_flag), 64'h1);
    up_down = 1'b1;

`ifndef BCD_MODE_EN
    rollover_val = 8'h20;
    do_load(8'hF0);
    do_step();
    chk("above_rv", 64'(count_out), 64'h00);
    chk("above_rv_flag", 64'(rollover_flag), 64'h1);
`else
    rollover_val = 8'h99;
    do_load(8'h09);
    do_step();
    chk("bcd_09_up", 64'(count_out), 64'h10);
    do_load(8'h99);
    do_step();
    chk("bcd_99_up", 64'(count_out), 64'h00);
    chk("bcd_99_flag", 64'(rollover_flag), 64'h1);
    up_down = 1'b0;
    do_step();
    chk("bcd_00_down", 64'(count_out), 64'h99);
    chk("bcd_00_flag", 64'(rollover_flag), 64'h1);
    do_load(8'h10);
    do_step();
    chk("bcd_10_down", 64'(count_out), 64'h09);
    up_down = 1'b1;
`endif

    // Random phase, checked every cycle by the model
    for (int i = 0; i < 2000; i++) begin
      rst          = ($urandom % 150) == 0;
      if (($urandom % 3) == 0) step_in = ~step_in;
      count_enable = ($urandom % 4) != 0;
      up_down      = $urandom % 2;
      clear        = ($urandom % 40) == 0;
      load         = ($urandom % 25) == 0;
      load_val     = rand_val();
      if (($urandom % 12) == 0)
        rollover_val = ($urandom % 2) ? rand_val() : bump('0, int'($urandom_range(0, 9)));
      tick(1);
    end
    rst = 1'b0; clear = 1'b0; load = 1'b0;
    tick(5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
